// File: rtl/conv_pkg.sv
// Shared convolution constants and window packing helpers.
// Used by the window feeder and the conv layer so both agree on element order.
package conv_pkg;

    localparam int CONV_K     = 6;
    localparam int CONV_PIX_W = 1;

    // Flat KxK window at the default geometry.
    typedef logic [CONV_K*CONV_K*CONV_PIX_W-1:0] win_vec_t;

    // Element (r,c) of a flat window, r=0 oldest row, c=0 leftmost column.
    function automatic int unsigned win_idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned k = CONV_K
    );
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row line buffer: one read and one write per cycle at the same column.
// Ports: clk, we (write strobe), col (column), wdata (new pixel),
//   rdata (K-1 column pixels, oldest row at index 0, read before write).
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int K     = CONV_K,
    parameter int PIX_W = CONV_PIX_W,
    localparam int CW   = $clog2(IMG_W)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [CW-1:0]          col,
    input  logic [PIX_W-1:0]       wdata,
    output logic [(K-1)*PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [K-1][IMG_W];

    always_comb begin
        rdata = '0;
        for (int j = 0; j < K-1; j++) begin
            rdata[j*PIX_W +: PIX_W] = mem[j][col];
        end
    end

    // Each write ages the column by one row; the newest pixel lands on top.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < K-2; j++) begin
                mem[j][col] <= mem[j+1][col];
            end
            mem[K-2][col] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Turns a raster pixel stream into KxK windows for the convolution layer.
// Ports: clk, rst (sync, high); pix_valid/pix_ready/pix_data/pix_last in;
//   win_valid/win_ready/win_data/win_row/win_col out; frame_err sticky.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int K     = CONV_K,
    parameter int PIX_W = CONV_PIX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [PIX_W-1:0]           pix_data,
    input  logic                       pix_last,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [K*K*PIX_W-1:0]       win_data,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_err
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);

    typedef enum logic {
        FILL,
        STREAM
    } state_t;

    state_t state;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    logic pix_acc;
    logic at_end;
    logic last_err;
    logic emit;

    logic [(K-1)*PIX_W-1:0] lb_col;
    logic [PIX_W-1:0]       win_q   [K][K];
    logic [PIX_W-1:0]       win_nxt [K][K];
    logic [K*K*PIX_W-1:0]   win_flat;

    assign pix_ready = !rst && (!win_valid || win_ready);
    assign pix_acc   = pix_valid && pix_ready;
    assign at_end    = (row == ROW_LAST) && (col == COL_LAST);
    assign last_err  = pix_last != at_end;
    assign emit      = (state == STREAM) && (col >= COL_WIN);

    conv_line_buffer #(
        .IMG_W (IMG_W),
        .K     (K),
        .PIX_W (PIX_W)
    ) u_lb (
        .clk   (clk),
        .we    (pix_acc),
        .col   (col),
        .wdata (pix_data),
        .rdata (lb_col)
    );

    // A misplaced or missing pix_last restarts counting at (0,0).
    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (last_err) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
            col_nxt = col + CW'(1);
        end
    end

    // Window slides left by one column; the new column is the line
    // buffer contents above the incoming pixel.
    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) begin
                win_nxt[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K-1; r++) begin
            win_nxt[r][K-1] = lb_col[r*PIX_W +: PIX_W];
        end
        win_nxt[K-1][K-1] = pix_data;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[win_idx(r, c, K)*PIX_W +: PIX_W] = win_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            win_q <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            row       <= '0;
            col       <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (pix_acc) begin
                row <= row_nxt;
                col <= col_nxt;
                if (last_err) begin
                    frame_err <= 1'b1;
                end
                unique case (state)
                    FILL: begin
                        if (row_nxt >= ROW_WIN) begin
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (row_nxt < ROW_WIN) begin
                            state <= FILL;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
            if (pix_acc && emit) begin
                win_valid <= 1'b1;
                win_data  <= win_flat;
                win_row   <= row;
                win_col   <= col;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on an 8x8 frame, K=6, 8-bit pixels.
// Pixel value is row*8+col so every window element is known in advance.
module tb_conv_window_feeder;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int K  = 6;
    localparam int PW = 8;
    localparam int DW = K * K * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [PW-1:0] pix_data = '0;
    logic          pix_last = 1'b0;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic [DW-1:0] win_data;
    logic [2:0]    win_row;
    logic [2:0]    win_col;
    logic          frame_err;

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;
    bit mon_en   = 1'b0;

    int            q_row [$];
    int            q_col [$];
    logic [DW-1:0] q_dat [$];

    logic [DW-1:0] d;

    conv_window_feeder #(
        .IMG_W (W),
        .IMG_H (H),
        .K     (K),
        .PIX_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer: always ready, 50% random, or stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = 1'($urandom_range(0, 1));
            default: win_ready = 1'b0;
        endcase
    end

    // Backpressure check and window capture, mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pix_ready", DW'(pix_ready),
                DW'(!rst && !(win_valid && !win_ready)));
            if (!rst && win_valid && win_ready) begin
                q_row.push_back(int'(win_row));
                q_col.push_back(int'(win_col));
                q_dat.push_back(win_data);
            end
        end
    end

    function automatic logic [DW-1:0] exp_win(input int rr, input int cc);
        logic [DW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(r*K+c)*PW +: PW] = PW'((rr-K+1+r)*W + (cc-K+1+c));
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] dat_at(input int i);
        if (i < q_dat.size()) return q_dat[i];
        return '1;
    endfunction

    task automatic clear_q();
        q_row.delete();
        q_col.delete();
        q_dat.delete();
    endtask

    task automatic send_pixel(input int v, input bit last, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            pix_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_data  = PW'(v);
        pix_last  = last;
        @(negedge clk);
        while (!pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pix_accept", DW'(pix_ready), DW'(1));
        @(posedge clk);
        #1;
        pix_last = 1'b0;
    endtask

    task automatic send_frame(input int gapmax);
        for (int i = 0; i < W*H; i++) begin
            send_pixel(i, i == W*H-1,
                       gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        pix_valid = 1'b0;
        while (win_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", DW'(win_valid), DW'(0));
    endtask

    task automatic check_frame(input int base);
        int k;
        int idx;
        k = 0;
        for (int rr = K-1; rr < H; rr++) begin
            for (int cc = K-1; cc < W; cc++) begin
                idx = base + k;
                if (idx < q_row.size()) begin
                    chk("win_row", DW'(q_row[idx]), DW'(rr));
                    chk("win_col", DW'(q_col[idx]), DW'(cc));
                    chk("win_data", q_dat[idx], exp_win(rr, cc));
                end else begin
                    chk("win_missing", DW'(0), DW'(1));
                end
                k++;
            end
        end
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_win_valid", DW'(win_valid), DW'(0));
        chk("rst_win_data", win_data, DW'(0));
        chk("rst_win_row", DW'(win_row), DW'(0));
        chk("rst_win_col", DW'(win_col), DW'(0));
        chk("rst_frame_err", DW'(frame_err), DW'(0));
        chk("rst_pix_ready", DW'(pix_ready), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", DW'(pix_ready), DW'(1));
        @(posedge clk);
        #1;

        // Full frame, consumer always ready
        rdy_mode = 0;
        clear_q();
        send_frame(0);
        drain();
        chk("s1_count", DW'(q_row.size()), DW'(9));
        check_frame(0);
        d = dat_at(0);
        chk("s1_first_d0", DW'(d[7:0]), DW'(0));
        chk("s1_first_d35", DW'(d[DW-1 -: PW]), DW'(45));
        d = dat_at(8);
        chk("s1_last_d0", DW'(d[7:0]), DW'(18));

        // Random consumer stalls
        rdy_mode = 1;
        clear_q();
        send_frame(0);
        drain();
        rdy_mode = 0;
        chk("s2_count", DW'(q_row.size()), DW'(9));
        check_frame(0);

        // Two frames back to back
        clear_q();
        send_frame(0);
        send_frame(0);
        drain();
        chk("s3_count", DW'(q_row.size()), DW'(18));
        check_frame(0);
        check_frame(9);
        d = dat_at(9);
        chk("s3_second_d0", DW'(d[7:0]), DW'(0));

        // Early pix_last at pixel 40
        clear_q();
        for (int i = 0; i < 40; i++) begin
            send_pixel(i, 1'b0, 0);
        end
        chk("s4_err_before", DW'(frame_err), DW'(0));
        send_pixel(40, 1'b1, 0);
        chk("s4_err_set", DW'(frame_err), DW'(1));
        clear_q();
        send_frame(0);
        drain();
        chk("s4_count", DW'(q_row.size()), DW'(9));
        check_frame(0);
        chk("s4_err_sticky", DW'(frame_err), DW'(1));

        // Reset while a window is pending
        rdy_mode = 2;
        clear_q();
        for (int i = 0; i < 46; i++) begin
            send_pixel(i, 1'b0, 0);
        end
        pix_valid = 1'b0;
        @(negedge clk);
        chk("s5_pending", DW'(win_valid), DW'(1));
        chk("s5_pend_row", DW'(win_row), DW'(5));
        chk("s5_pend_col", DW'(win_col), DW'(5));
        chk("s5_pend_data", win_data, exp_win(5, 5));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_valid_clr", DW'(win_valid), DW'(0));
        chk("s5_data_clr", win_data, DW'(0));
        chk("s5_err_clr", DW'(frame_err), DW'(0));
        rst = 1'b0;
        rdy_mode = 0;
        clear_q();
        send_frame(0);
        drain();
        chk("s5_count", DW'(q_row.size()), DW'(9));
        check_frame(0);

        // Idle gaps on the input
        clear_q();
        send_frame(3);
        drain();
        chk("s6_count", DW'(q_row.size()), DW'(9));
        check_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
